// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I decode definitions.
//   - 7-bit major opcode constants for the eleven base-ISA opcodes
//   - alu_op_t   : operation requested from the execute-stage ALU
//   - imm_sel_t  : immediate format chosen by the decoder
//   - ctrl_t     : control bundle carried through the ID/EX register
//   - alu_decode : funct3 (+ alternate bit) to ALU operation mapping
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef struct packed {
    logic       use_imm;    // ALU operand B is the immediate
    logic       use_pc;     // ALU operand A is the PC
    logic       reg_write;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic [2:0] funct3;
  } ctrl_t;

  // alt selects SUB over ADD and SRA over SRL; the caller decides when
  // the alternate bit is meaningful.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr   : instruction bits [31:7] (the opcode field carries no immediate)
//   imm_sel : immediate format (I/S/B/U/J)
//   imm     : 32-bit immediate, sign-extended from instr[31]
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_sel_t    imm_sel,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I instruction decode stage with ID/EX pipeline register.
//   Upstream   : i_valid / o_ready handshake, i_instr, i_pc
//   Reg file   : o_rd_addr_1/2 (combinational rs1/rs2), i_rd_data_1/2
//   Writeback  : i_wb_we, i_wb_address, i_wb_data (bypassed into operands)
//   Control    : i_flush kills the instruction being decoded
//   Downstream : o_valid / i_ready handshake, o_pc, o_rs1_val, o_rs2_val,
//                o_imm, o_rd, o_alu_op, o_ctrl, o_illegal (all registered)
// A load in ID/EX whose rd is read by the decoding instruction stalls the
// input for one cycle and sends a bubble downstream.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_1,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_2,
  input  logic [DATA_WIDTH-1:0] i_rd_data_1,
  input  logic [DATA_WIDTH-1:0] i_rd_data_2,
  input  logic                  i_wb_we,
  input  logic [ADDR_WIDTH-1:0] i_wb_address,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_rs1_val,
  output logic [DATA_WIDTH-1:0] o_rs2_val,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [ADDR_WIDTH-1:0] o_rd,
  output alu_op_t               o_alu_op,
  output ctrl_t                 o_ctrl,
  output logic                  o_illegal
);

  // Instruction fields
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [ADDR_WIDTH-1:0] rs1, rs2, rd;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign rd     = i_instr[11:7];

  assign o_rd_addr_1 = rs1;
  assign o_rd_addr_2 = rs2;

  // Decoder
  ctrl_t    dec_ctrl;
  alu_op_t  dec_alu_op;
  imm_sel_t dec_imm_sel;
  logic     dec_illegal;
  logic     writes_rd;
  logic     uses_rs1, uses_rs2;

  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl.funct3 = funct3;
    dec_alu_op      = ALU_ADD;
    dec_imm_sel     = IMM_I;
    dec_illegal     = 1'b0;
    writes_rd       = 1'b0;
    uses_rs1        = 1'b1;
    uses_rs2        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_imm_sel      = IMM_U;
        dec_alu_op       = ALU_PASS_B;
        dec_ctrl.use_imm = 1'b1;
        writes_rd        = 1'b1;
        uses_rs1         = 1'b0;
      end
      OPC_AUIPC: begin
        dec_imm_sel      = IMM_U;
        dec_ctrl.use_imm = 1'b1;
        dec_ctrl.use_pc  = 1'b1;
        writes_rd        = 1'b1;
        uses_rs1         = 1'b0;
      end
      OPC_JAL: begin
        dec_imm_sel      = IMM_J;
        dec_ctrl.use_imm = 1'b1;
        dec_ctrl.use_pc  = 1'b1;
        dec_ctrl.is_jal  = 1'b1;
        writes_rd        = 1'b1;
        uses_rs1         = 1'b0;
      end
      OPC_JALR: begin
        dec_ctrl.use_imm = 1'b1;
        dec_ctrl.is_jalr = 1'b1;
        writes_rd        = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm_sel        = IMM_B;
        dec_alu_op         = ALU_SUB;
        dec_ctrl.is_branch = 1'b1;
        uses_rs2           = 1'b1;
        dec_illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec_ctrl.use_imm = 1'b1;
        dec_ctrl.is_load = 1'b1;
        writes_rd        = 1'b1;
        dec_illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec_imm_sel       = IMM_S;
        dec_ctrl.use_imm  = 1'b1;
        dec_ctrl.is_store = 1'b1;
        uses_rs2          = 1'b1;
        dec_illegal       = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        // instr[30] is part of the immediate except for the shift-right form
        dec_ctrl.use_imm = 1'b1;
        dec_alu_op       = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
        writes_rd        = 1'b1;
      end
      OPC_OP: begin
        dec_alu_op  = alu_decode(funct3, funct7[5]);
        writes_rd   = 1'b1;
        uses_rs2    = 1'b1;
        dec_illegal = !((funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // FENCE / ECALL / EBREAK retire as no-ops in this pipeline
      end
      default: dec_illegal = 1'b1;
    endcase
    if (i_instr[1:0] != 2'b11) dec_illegal = 1'b1;
    dec_ctrl.reg_write = writes_rd && (rd != '0);
    // An illegal instruction must not have architectural side effects
    if (dec_illegal) begin
      dec_ctrl   = '0;
      dec_alu_op = ALU_ADD;
    end
  end

  logic [31:0] dec_imm;

  imm_gen u_imm_gen (
    .instr   (i_instr[31:7]),
    .imm_sel (dec_imm_sel),
    .imm     (dec_imm)
  );

  // Operand select: x0 reads zero, then writeback bypass, then reg file
  logic [ADDR_WIDTH-1:0] op_addr [2];
  logic [DATA_WIDTH-1:0] op_rf   [2];
  logic [DATA_WIDTH-1:0] op_val  [2];

  assign op_addr[0] = rs1;
  assign op_addr[1] = rs2;
  assign op_rf[0]   = i_rd_data_1;
  assign op_rf[1]   = i_rd_data_2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign op_val[gi] = (op_addr[gi] == '0)                        ? '0 :
                        (i_wb_we && (i_wb_address == op_addr[gi])) ? i_wb_data :
                                                                     op_rf[gi];
  end

  // ID/EX register
  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] pc_reg, rs1_val_reg, rs2_val_reg, imm_reg;
  logic [ADDR_WIDTH-1:0] rd_reg;
  alu_op_t               alu_op_reg;
  ctrl_t                 ctrl_reg;
  logic                  illegal_reg;

  logic advance, hazard, capture_next;

  assign advance = !valid_reg || i_ready;
  assign hazard  = valid_reg && ctrl_reg.is_load && (rd_reg != '0) && i_valid &&
                   ((uses_rs1 && (rs1 == rd_reg)) || (uses_rs2 && (rs2 == rd_reg)));
  // A flush consumes the input even while a load-use stall is pending
  assign o_ready      = advance && (!hazard || i_flush);
  assign capture_next = i_valid && !i_flush && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      pc_reg      <= '0;
      rs1_val_reg <= '0;
      rs2_val_reg <= '0;
      imm_reg     <= '0;
      rd_reg      <= '0;
      alu_op_reg  <= ALU_ADD;
      ctrl_reg    <= '0;
      illegal_reg <= 1'b0;
    end else if (advance) begin
      valid_reg <= capture_next;
      if (capture_next) begin
        pc_reg      <= i_pc;
        rs1_val_reg <= op_val[0];
        rs2_val_reg <= op_val[1];
        imm_reg     <= dec_imm;
        rd_reg      <= rd;
        alu_op_reg  <= dec_alu_op;
        ctrl_reg    <= dec_ctrl;
        illegal_reg <= dec_illegal;
      end else begin
        // Bubbles are driven to an all-zero payload
        pc_reg      <= '0;
        rs1_val_reg <= '0;
        rs2_val_reg <= '0;
        imm_reg     <= '0;
        rd_reg      <= '0;
        alu_op_reg  <= ALU_ADD;
        ctrl_reg    <= '0;
        illegal_reg <= 1'b0;
      end
    end
  end

  assign o_valid   = valid_reg;
  assign o_pc      = pc_reg;
  assign o_rs1_val = rs1_val_reg;
  assign o_rs2_val = rs2_val_reg;
  assign o_imm     = imm_reg;
  assign o_rd      = rd_reg;
  assign o_alu_op  = alu_op_reg;
  assign o_ctrl    = ctrl_reg;
  assign o_illegal = illegal_reg;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage with hand-computed results.
module tb_id_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic [4:0]  o_rd_addr_1, o_rd_addr_2;
  logic [31:0] i_rd_data_1 = '0, i_rd_data_2 = '0;
  logic        i_wb_we = 1'b0;
  logic [4:0]  i_wb_address = '0;
  logic [31:0] i_wb_data = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_pc, o_rs1_val, o_rs2_val, o_imm;
  logic [4:0]  o_rd;
  alu_op_t     o_alu_op;
  ctrl_t       o_ctrl;
  logic        o_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc),
    .o_rd_addr_1(o_rd_addr_1), .o_rd_addr_2(o_rd_addr_2),
    .i_rd_data_1(i_rd_data_1), .i_rd_data_2(i_rd_data_2),
    .i_wb_we(i_wb_we), .i_wb_address(i_wb_address), .i_wb_data(i_wb_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val), .o_imm(o_imm),
    .o_rd(o_rd), .o_alu_op(o_alu_op), .o_ctrl(o_ctrl), .o_illegal(o_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    i_valid = v;
    i_instr = instr;
    i_pc    = pc;
  endtask

  task automatic test_reset();
    ctrl_t exp_ctrl;
    exp_ctrl = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
    n_vec++; if (o_alu_op !== ALU_ADD) begin n_err++; $display("FAIL reset_alu_op: got %0d expected %0d", o_alu_op, ALU_ADD); end
    n_vec++; if (o_ctrl !== exp_ctrl) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", o_ctrl, exp_ctrl); end
    n_vec++; if (o_imm !== 32'h0 || o_pc !== 32'h0 || o_illegal !== 1'b0) begin n_err++; $display("FAIL reset_payload: got imm=%h pc=%h ill=%0b expected 0", o_imm, o_pc, o_illegal); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b expected 1", o_ready); end
    $display("txn reset released");
  endtask

  task automatic test_addi();
    ctrl_t exp_ctrl;
    exp_ctrl = '0; exp_ctrl.use_imm = 1'b1; exp_ctrl.reg_write = 1'b1;
    i_ready = 1'b1; i_flush = 1'b0; i_wb_we = 1'b0; i_rd_data_1 = '0; i_rd_data_2 = '0;
    drive(1'b1, 32'h00500093, 32'h100);
    #1;
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL addi_ready: got %0b expected 1", o_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %0b expected 1", o_valid); end
    n_vec++; if (o_rd !== 5'd1) begin n_err++; $display("FAIL addi_rd: got %0d expected 1", o_rd); end
    n_vec++; if (o_imm !== 32'd5) begin n_err++; $display("FAIL addi_imm: got %h expected 00000005", o_imm); end
    n_vec++; if (o_alu_op !== ALU_ADD) begin n_err++; $display("FAIL addi_alu_op: got %0d expected %0d", o_alu_op, ALU_ADD); end
    n_vec++; if (o_ctrl !== exp_ctrl) begin n_err++; $display("FAIL addi_ctrl: got %h expected %h", o_ctrl, exp_ctrl); end
    n_vec++; if (o_illegal !== 1'b0) begin n_err++; $display("FAIL addi_illegal: got %0b expected 0", o_illegal); end
    n_vec++; if (o_pc !== 32'h100) begin n_err++; $display("FAIL addi_pc: got %h expected 00000100", o_pc); end
    $display("txn addi x1,x0,5 imm=%h rd=%0d", o_imm, o_rd);
  endtask

  task automatic test_branch();
    ctrl_t exp_ctrl;
    exp_ctrl = '0; exp_ctrl.is_branch = 1'b1;
    i_rd_data_1 = 32'h11; i_rd_data_2 = 32'h22;
    drive(1'b1, 32'hFE208EE3, 32'h104);
    #1;
    n_vec++; if (o_rd_addr_1 !== 5'd1 || o_rd_addr_2 !== 5'd2) begin n_err++; $display("FAIL beq_rd_addr: got %0d/%0d expected 1/2", o_rd_addr_1, o_rd_addr_2); end
    tick();
    n_vec++; if (o_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL beq_imm: got %h expected fffffffc", o_imm); end
    n_vec++; if (o_alu_op !== ALU_SUB) begin n_err++; $display("FAIL beq_alu_op: got %0d expected %0d", o_alu_op, ALU_SUB); end
    n_vec++; if (o_ctrl !== exp_ctrl) begin n_err++; $display("FAIL beq_ctrl: got %h expected %h", o_ctrl, exp_ctrl); end
    n_vec++; if (o_rs1_val !== 32'h11 || o_rs2_val !== 32'h22) begin n_err++; $display("FAIL beq_operands: got %h/%h expected 11/22", o_rs1_val, o_rs2_val); end
    $display("txn beq x1,x2,-4 imm=%h", o_imm);
  endtask

  task automatic test_load_use();
    i_rd_data_1 = '0; i_rd_data_2 = '0;
    drive(1'b1, 32'h0000A103, 32'h108);
    #1;
    tick();
    n_vec++; if (o_valid !== 1'b1 || o_ctrl.is_load !== 1'b1 || o_rd !== 5'd2) begin n_err++; $display("FAIL lw_issue: got v=%0b ld=%0b rd=%0d expected 1/1/2", o_valid, o_ctrl.is_load, o_rd); end
    drive(1'b1, 32'h002101B3, 32'h10C);
    #1;
    n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall_ready: got %0b expected 0", o_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %0b expected 0", o_valid); end
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL lu_resume_ready: got %0b expected 1", o_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b1 || o_rd !== 5'd3 || o_pc !== 32'h10C) begin n_err++; $display("FAIL lu_add_issue: got v=%0b rd=%0d pc=%h expected 1/3/0000010c", o_valid, o_rd, o_pc); end
    $display("txn lw x2 / add x3,x2,x2 with one bubble");
  endtask

  task automatic test_bypass();
    i_rd_data_1 = 32'h0; i_rd_data_2 = 32'h5555;
    i_wb_we = 1'b1; i_wb_address = 5'd5; i_wb_data = 32'hDEADBEEF;
    drive(1'b1, 32'h00028333, 32'h110);
    #1;
    n_vec++; if (o_rd_addr_1 !== 5'd5) begin n_err++; $display("FAIL byp_rd_addr: got %0d expected 5", o_rd_addr_1); end
    tick();
    n_vec++; if (o_rs1_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL byp_rs1: got %h expected deadbeef", o_rs1_val); end
    n_vec++; if (o_rs2_val !== 32'h0) begin n_err++; $display("FAIL byp_rs2_x0: got %h expected 0", o_rs2_val); end
    i_wb_address = 5'd7; i_rd_data_1 = 32'h1111;
    tick();
    n_vec++; if (o_rs1_val !== 32'h1111) begin n_err++; $display("FAIL byp_addr_miss: got %h expected 00001111", o_rs1_val); end
    i_wb_we = 1'b0; i_wb_address = 5'd5;
    tick();
    n_vec++; if (o_rs1_val !== 32'h1111) begin n_err++; $display("FAIL byp_we_off: got %h expected 00001111", o_rs1_val); end
    $display("txn add x6,x5,x0 bypass rs1=%h", o_rs1_val);
  endtask

  task automatic test_x0_illegal();
    i_wb_we = 1'b1; i_wb_address = 5'd0; i_wb_data = 32'd7; i_rd_data_1 = 32'h1234;
    drive(1'b1, 32'h00500093, 32'h120);
    tick();
    n_vec++; if (o_rs1_val !== 32'h0) begin n_err++; $display("FAIL x0_guard: got %h expected 0", o_rs1_val); end
    i_wb_we = 1'b0;
    drive(1'b1, 32'h00000000, 32'h124);
    tick();
    n_vec++; if (o_valid !== 1'b1 || o_illegal !== 1'b1) begin n_err++; $display("FAIL zero_illegal: got v=%0b ill=%0b expected 1/1", o_valid, o_illegal); end
    n_vec++; if (o_ctrl.reg_write !== 1'b0) begin n_err++; $display("FAIL zero_reg_write: got %0b expected 0", o_ctrl.reg_write); end
    $display("txn x0 guard and instr 00000000 illegal=%0b", o_illegal);
  endtask

  task automatic test_decode_table();
    logic [31:0] t_instr [11];
    logic [31:0] t_imm   [11];
    alu_op_t     t_alu   [11];
    logic        t_ill   [11];
    logic        t_rw    [11];
    t_instr = '{32'h403100B3, 32'h4030D093, 32'h40000093, 32'h123452B7, 32'h008000EF,
                32'hFE20AC23, 32'h0000000F, 32'h00000073, 32'h00000000, 32'h400010B3, 32'h00003083};
    t_imm   = '{32'h403, 32'h403, 32'h400, 32'h12345000, 32'h8,
                32'hFFFFFFF8, 32'h0, 32'h0, 32'h0, 32'h400, 32'h0};
    t_alu   = '{ALU_SUB, ALU_SRA, ALU_ADD, ALU_PASS_B, ALU_ADD,
                ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD};
    t_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t_rw    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    i_wb_we = 1'b0; i_rd_data_1 = '0; i_rd_data_2 = '0;
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, t_instr[k], 32'h200 + 32'(k * 4));
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_imm !== t_imm[k] || o_alu_op !== t_alu[k] ||
          o_illegal !== t_ill[k] || o_ctrl.reg_write !== t_rw[k]) begin
        n_err++;
        $display("FAIL decode[%0d] %h: got v=%0b imm=%h alu=%0d ill=%0b rw=%0b expected v=1 imm=%h alu=%0d ill=%0b rw=%0b",
                 k, t_instr[k], o_valid, o_imm, o_alu_op, o_illegal, o_ctrl.reg_write,
                 t_imm[k], t_alu[k], t_ill[k], t_rw[k]);
      end
      $display("txn decode %h imm=%h alu=%0d ill=%0b", t_instr[k], o_imm, o_alu_op, o_illegal);
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h300);
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bp_fill: got %0b expected 1", o_valid); end
    i_ready = 1'b0;
    drive(1'b1, 32'h123452B7, 32'h304);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %0b expected 0", k, o_ready); end
      tick();
      n_vec++; if (o_valid !== 1'b1 || o_imm !== 32'd5 || o_pc !== 32'h300) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%0b imm=%h pc=%h expected 1/00000005/00000300", k, o_valid, o_imm, o_pc); end
    end
    i_ready = 1'b1;
    #1;
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b expected 1", o_ready); end
    tick();
    n_vec++; if (o_imm !== 32'h12345000 || o_pc !== 32'h304) begin n_err++; $display("FAIL bp_release: got imm=%h pc=%h expected 12345000/00000304", o_imm, o_pc); end
    $display("txn back-pressure 3 cycles then lui");
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0000A103, 32'h400);
    tick();
    drive(1'b1, 32'h002101B3, 32'h404);
    i_flush = 1'b1;
    #1;
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %0b expected 1", o_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b0 || o_pc !== 32'h0) begin n_err++; $display("FAIL flush_kill: got v=%0b pc=%h expected 0/0", o_valid, o_pc); end
    i_flush = 1'b0;
    #1;
    tick();
    n_vec++; if (o_valid !== 1'b1 || o_rd !== 5'd3) begin n_err++; $display("FAIL flush_after: got v=%0b rd=%0d expected 1/3", o_valid, o_rd); end
    $display("txn flush over load-use stall");
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h00500093, 32'h500);
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got %0b expected 1", o_valid); end
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_alu_op !== ALU_ADD) begin n_err++; $display("FAIL areset_now: got v=%0b pc=%h alu=%0d expected 0/0/0", o_valid, o_pc, o_alu_op); end
    #2 rst = 1'b0;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL areset_after: got %0b expected 0", o_valid); end
    $display("txn asynchronous reset mid-cycle");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_load_use();
    test_bypass();
    test_x0_illegal();
    test_decode_table();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage. Sits directly upstream of register_file and drives its two read addresses.
- Decodes the fetched instruction and generates the immediate. Merges register_file read data with a writeback bypass.
- Registers the result into the ID/EX pipeline register for execute, using valid/ready handshakes on both sides.
- Detects load-use hazards and stalls by inserting a bubble.

Parameters:
ADDR_WIDTH, 5, register address width (32 registers)
DATA_WIDTH, 32, data/instruction/PC width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
i_valid  input  1  upstream instruction valid
o_ready  output  1  stage accepts upstream instruction this cycle
i_instr  input  DATA_WIDTH  instruction word
i_pc  input  DATA_WIDTH  instruction PC
o_rd_addr_1  output  ADDR_WIDTH  rs1 field to register_file (combinational from i_instr)
o_rd_addr_2  output  ADDR_WIDTH  rs2 field to register_file (combinational from i_instr)
i_rd_data_1  input  DATA_WIDTH  register_file read data 1 (combinational)
i_rd_data_2  input  DATA_WIDTH  register_file read data 2 (combinational)
i_wb_we  input  1  writeback write enable (same signal driving register_file i_we)
i_wb_address  input  ADDR_WIDTH  writeback address
i_wb_data  input  DATA_WIDTH  writeback data
i_flush  input  1  kill in-flight instruction (branch/jump redirect)
o_valid  output  1  ID/EX register valid
i_ready  input  1  execute accepts ID/EX contents
o_pc  output  DATA_WIDTH  registered PC
o_rs1_val  output  DATA_WIDTH  registered operand 1
o_rs2_val  output  DATA_WIDTH  registered operand 2
o_imm  output  DATA_WIDTH  registered sign-extended immediate
o_rd  output  ADDR_WIDTH  registered destination register
o_alu_op  output  4  registered alu_op_t
o_ctrl  output  ctrl_t  registered control bundle: use_imm, use_pc, reg_write, is_load, is_store, is_branch, is_jal, is_jalr, funct3
o_illegal  output  1  registered illegal-instruction flag

Behaviour:
- Reset (async, rst=1): all outputs 0, o_alu_op=ALU_ADD. Applies immediately mid-operation. The in-flight instruction is lost.
- advance = !o_valid || i_ready. The ID/EX register updates only on clock edges where advance=1. Otherwise it holds.
- hazard = o_valid && o_ctrl.is_load && o_rd!=0 && i_valid && ((uses_rs1 && rs1==o_rd) || (uses_rs2 && rs2==o_rd)).
  - uses_rs1 is false for LUI/AUIPC/JAL.
  - uses_rs2 is true only for OP/BRANCH/STORE.
- o_ready = advance && (!hazard || i_flush).
- Next-state priority on an advancing edge:
  1. i_flush: o_valid<=0; the input is consumed and discarded.
  2. hazard: o_valid<=0 (bubble); the input is held.
  3. Otherwise: o_valid<=i_valid and the payload is captured.
- Load-use latency: exactly one bubble per hazard.
- Operand select per operand:
  - address==0 → 0, regardless of i_rd_data or bypass.
  - else if i_wb_we && i_wb_address==address → i_wb_data.
  - else i_rd_data.
- Immediates, all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
- ALU op:
  - OP: from funct3/funct7[5]. SUB/SRA are selected when funct7[5]=1.
  - OP-IMM: funct7[5] is honoured only for SRAI.
  - LOAD/STORE/AUIPC/JAL/JALR: ADD.
  - LUI: PASS_B.
  - BRANCH: SUB.
- Illegal (o_illegal=1, reg_write=0, is_load=0, is_store=0) when any of:
  - opcode is not one of the 11 RV32I opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM);
  - instr[1:0]!=2'b11;
  - OP funct7 is not in {0x00,0x20}, or is 0x20 with funct3 not in {000,101};
  - funct3 is invalid for BRANCH/LOAD/STORE.
- FENCE/ECALL/EBREAK decode as NOP: reg_write=0, not illegal.
- reg_write=0 whenever rd==0.
- Bubbles carry o_valid=0. The payload is don't-care but is driven to 0.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams;
  - alu_op_t enum {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B};
  - imm_sel_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J};
  - ctrl_t packed struct.
- Sub-module imm_gen (combinational: instr, imm_sel → imm).

Test Plan:
- ADDI x1,x0,5 (0x00500093), i_valid=1, i_ready=1 → next edge: o_valid=1, o_rd=1, o_imm=5, o_alu_op=ALU_ADD, use_imm=1, reg_write=1, o_illegal=0.
- BEQ x1,x2,-4 (0xFE208EE3) → o_imm=0xFFFFFFFC, is_branch=1, o_alu_op=ALU_SUB, reg_write=0, o_rd_addr_1=1, o_rd_addr_2=2.
- LW x2,0(x1) (0x0000A103), then ADD x3,x2,x2 (0x002101B3), i_ready=1 → cycle after LW: o_ready=0, then o_valid=0 for one cycle; ADD is issued on the following cycle, o_ready=1.
- Bypass: i_rd_data_1=0, i_wb_we=1, i_wb_address=5, i_wb_data=0xDEADBEEF, decoding ADD x6,x5,x0 → o_rs1_val=0xDEADBEEF, o_rs2_val=0.
- x0 guard and illegal: i_wb_address=0, i_wb_data=7, i_rd_data_1=0x1234, rs1=0 → o_rs1_val=0. Instruction 0x00000000 → o_illegal=1, reg_write=0.
- Back-pressure, flush and reset:
  - i_ready=0 for 3 cycles → payload held stable, o_ready=0.
  - i_flush=1 → next edge o_valid=0.
  - rst pulsed between clock edges → o_valid drops immediately, without waiting for a clock edge.
